// File: rtl/ifetch_refill_if.sv
`default_nettype none
// ============================================================================
// ifetch_refill_if : consumer and backing-memory signals of the refill engine
// Revision: 1.0
// ============================================================================
interface ifetch_refill_if #(
  parameter int AW = 10
);
  logic          Start;
  logic [AW-1:0] Start_Addr;
  logic          Switch;
  logic          Flush;
  logic          Mem_Req;
  logic [AW-1:0] Mem_Addr;
  logic          Mem_Ack;
  logic [31:0]   Mem_Rdata;
  logic          Fill_Valid;
  logic [2:0]    Fill_Index;
  logic [31:0]   Fill_Data;
  logic [AW-1:0] Fill_Base;
  logic          Line_Ready;
  logic          Stall;

  modport master (
    output Start, Start_Addr, Switch, Flush, Mem_Ack, Mem_Rdata,
    input  Mem_Req, Mem_Addr, Fill_Valid, Fill_Index, Fill_Data,
           Fill_Base, Line_Ready, Stall
  );

  modport slave (
    input  Start, Start_Addr, Switch, Flush, Mem_Ack, Mem_Rdata,
    output Mem_Req, Mem_Addr, Fill_Valid, Fill_Index, Fill_Data,
           Fill_Base, Line_Ready, Stall
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_refill.sv
`default_nettype none
// ============================================================================
// ifetch_refill : prefetches the next 8-word line into the inactive half of a
//                 switching instruction cache, with stall on early switch.
// Revision: 1.0
// ============================================================================
module ifetch_refill #(
  parameter int LINE_WORDS = 8,
  parameter int AW         = 10
) (
  input  wire logic         clk,
  input  wire logic         Reset_n,
  ifetch_refill_if.slave    bus
);

  localparam int          c_IDX_W = 3;
  localparam logic [AW-1:0] c_LINE_STEP = AW'(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_base;
  logic [c_IDX_W-1:0]  r_cnt;
  logic                r_pend;
  logic                r_fv;
  logic [c_IDX_W-1:0]  r_idx;
  logic [31:0]         r_data;
  logic                r_lr;
  logic                r_stall;

  state_t              w_state_nxt;
  logic [AW-1:0]       w_base_nxt;
  logic [c_IDX_W-1:0]  w_cnt_nxt;
  logic                w_pend_nxt;
  logic                w_fv_nxt;
  logic [c_IDX_W-1:0]  w_idx_nxt;
  logic [31:0]         w_data_nxt;
  logic                w_lr_nxt;
  logic                w_stall_nxt;
  logic                w_xfer;
  logic                w_last;
  logic [AW-1:0]       w_word_addr;

  always_comb begin
    w_word_addr = r_base + {{(AW-c_IDX_W){1'b0}}, r_cnt};
    w_xfer      = (r_state == S_FILL) && bus.Mem_Ack;
    w_last      = w_xfer && (r_cnt == 3'd7);

    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_fv_nxt    = 1'b0;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_lr_nxt    = r_lr;
    w_stall_nxt = r_stall;

    if (bus.Flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_pend_nxt  = 1'b0;
      w_lr_nxt    = 1'b0;
      w_stall_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            w_base_nxt  = {bus.Start_Addr[AW-1:c_IDX_W], {c_IDX_W{1'b0}}} + c_LINE_STEP;
            w_cnt_nxt   = '0;
            w_state_nxt = S_FILL;
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            w_fv_nxt   = 1'b1;
            w_idx_nxt  = r_cnt;
            w_data_nxt = bus.Mem_Rdata;
            w_cnt_nxt  = r_cnt + 3'd1;
          end
          if (w_last) begin
            // A switch pending (or arriving now) skips READY and starts the next line at once
            if (r_pend || bus.Switch) begin
              w_base_nxt  = r_base + c_LINE_STEP;
              w_cnt_nxt   = '0;
              w_pend_nxt  = 1'b0;
              w_stall_nxt = 1'b0;
            end else begin
              w_state_nxt = S_READY;
              w_lr_nxt    = 1'b1;
            end
          end else if (bus.Switch && !r_pend) begin
            w_pend_nxt  = 1'b1;
            w_stall_nxt = 1'b1;
          end
        end
        S_READY: begin
          if (bus.Switch) begin
            w_lr_nxt    = 1'b0;
            w_base_nxt  = r_base + c_LINE_STEP;
            w_cnt_nxt   = '0;
            w_state_nxt = S_FILL;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_fv    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_lr    <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_fv    <= w_fv_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_lr    <= w_lr_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  // Address is forced to zero outside FILL so an idle bus carries no stale address
  assign bus.Mem_Req    = (r_state == S_FILL);
  assign bus.Mem_Addr   = (r_state == S_FILL) ? w_word_addr : '0;
  assign bus.Fill_Valid = r_fv;
  assign bus.Fill_Index = r_idx;
  assign bus.Fill_Data  = r_data;
  assign bus.Fill_Base  = r_base;
  assign bus.Line_Ready = r_lr;
  assign bus.Stall      = r_stall;

endmodule
`default_nettype wire

// File: doc/ifetch_refill.md
IFETCH_REFILL -- requirements
Module: ifetch_refill

Interface
REQ-001 Parameter LINE_WORDS, default 8, is the words per switching-cache line; fixed at 8, so the fill index is 3 bits.
REQ-002 Parameter AW, default 10, is the instruction word-address width.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port Reset_n  input  1  is the synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 Port Start  input  1  is a one-cycle pulse that begins prefetching the line after Start_Addr.
REQ-006 Port Start_Addr  input  AW  is the word address currently being fetched.
REQ-007 Port Switch  input  1  is a one-cycle pulse: the consumer retired the active line and now reads the filled line.
REQ-008 Port Flush  input  1  aborts all activity and returns the block to IDLE.
REQ-009 Port Mem_Req  output  1  is the backing-memory read request.
REQ-010 Port Mem_Addr  output  AW  is the backing-memory word address.
REQ-011 Port Mem_Ack  input  1  means read data is valid this cycle; the transfer occurs when Mem_Req and Mem_Ack are both 1.
REQ-012 Port Mem_Rdata  input  32  is the backing-memory read data.
REQ-013 Port Fill_Valid  output  1  writes Fill_Data into the inactive line at Fill_Index.
REQ-014 Port Fill_Index  output  3  is the word offset within the line.
REQ-015 Port Fill_Data  output  32  is the instruction word being written.
REQ-016 Port Fill_Base  output  AW  is the line base (lb) of the line being filled.
REQ-017 Port Line_Ready  output  1  means all 8 words of the Fill_Base line are written.
REQ-018 Port Stall  output  1  means a Switch arrived before the line was ready.

Function
REQ-019 States SHALL be: IDLE, FILL, READY.
- IDLE: Mem_Req=0.
- FILL: issuing word reads.
- READY: line complete; waiting for Switch.
REQ-020 In IDLE, Start SHALL load Fill_Base={Start_Addr[AW-1:3],3'b000}+8 (mod 2^AW), clear the word counter, and enter FILL.
REQ-021 In FILL, Mem_Req=1 and Mem_Addr=Fill_Base+counter; Mem_Addr SHALL stay stable until the transfer.
REQ-022 Each transfer SHALL register Fill_Valid=1, Fill_Data=Mem_Rdata, Fill_Index=counter on the next cycle (1-cycle latency); otherwise Fill_Valid=0.
REQ-023 The counter SHALL increment once per transfer; the transfer at counter=7 SHALL enter READY and set Line_Ready=1 in the same cycle as the final Fill_Valid.
REQ-024 No more than one transfer per cycle; Mem_Req SHALL drop to 0 in the cycle after the 8th transfer.
REQ-025 In READY, Switch SHALL clear Line_Ready, advance Fill_Base by 8 (wraps 1016 -> 0), clear the counter, and enter FILL.
REQ-026 Switch in FILL SHALL set Stall=1 and record a pending switch; completing the line SHALL apply the pending switch immediately (READY not held), and Stall SHALL clear in that cycle.
REQ-027 A second Switch while one is pending SHALL be ignored.
REQ-028 Start outside IDLE SHALL be ignored.
REQ-029 Flush SHALL take priority over Start, Switch and Mem_Ack in the same cycle; next cycle: IDLE, Mem_Req=0, Line_Ready=0, Stall=0, pending switch cleared, Fill_Valid=0.
REQ-030 A Mem_Ack with Mem_Req=0 SHALL be ignored.

Reset
REQ-031 Reset_n=0 at a clk edge SHALL force IDLE with outputs Mem_Req=0, Mem_Addr=0, Fill_Valid=0, Fill_Index=0, Fill_Data=0, Fill_Base=0, Line_Ready=0, Stall=0, and the counter and pending switch cleared.
REQ-032 Reset SHALL override every other input.
REQ-033 Reset mid-FILL SHALL abandon the line with no further Fill_Valid.

Verification
REQ-034 Start, Start_Addr=3, Mem_Ack always 1 -> Mem_Addr 8..15 on consecutive cycles, Fill_Index 0..7, Line_Ready=1 with the Index 7 write, then Mem_Req=0.
REQ-035 In READY with Fill_Base=1016, Switch -> Fill_Base=0, Mem_Addr=0, FILL.
REQ-036 Mem_Ack held low 5 cycles at counter=2 -> Mem_Addr held at base+2, no Fill_Valid, Mem_Req=1 throughout.
REQ-037 Switch at counter=4 -> Stall=1 until the 8th transfer, then FILL restarts at base+8 with Line_Ready never observed high.
REQ-038 Flush and Start asserted together during FILL -> IDLE next cycle, Mem_Req=0, Start not taken.
REQ-039 Reset_n=0 with Mem_Ack=1 at counter=6 -> all outputs zero next cycle, no Fill_Valid.
